crypto_op_sequencer: RTL

- Multi-cycle sequencer between the control unit and a shared scalar crypto datapath (AES32/SM4 block ops, SHA256/SHA512/SM3 hash ops).
- Accepts one decoded crypto op at a time, checks that it is legal, and issues it to the datapath.
- Holds the core via stall while the op runs, watches for a timeout, then presents one writeback beat.

---
 rtl/crypto_seq_pkg.sv | 41 ++++
 rtl/crypto_onehot_chk.sv | 15 +
 rtl/crypto_op_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/crypto_seq_pkg.sv
// Shared types and constants for the scalar crypto op sequencer: state encoding,
// layout of crypto_instruction ({bs, 18 one-hot op bits}) and default timeout.
package crypto_seq_pkg;

  localparam int OP_W        = 20;
  localparam int OP_BITS_LSB = 0;
  localparam int OP_BITS_MSB = 17;
  localparam int BS_LSB      = 18;
  localparam int BS_MSB      = 19;

  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  // Bit position of each op inside crypto_instruction
  localparam int OP_SAES32_ENCS  = 17;
  localparam int OP_SAES32_ENCSM = 16;
  localparam int OP_SAES32_DECS  = 15;
  localparam int OP_SAES32_DECSM = 14;
  localparam int OP_SHA256SIG0   = 13;
  localparam int OP_SHA256SIG1   = 12;
  localparam int OP_SHA256SUM0   = 11;
  localparam int OP_SHA256SUM1   = 10;
  localparam int OP_SHA512SIG0H  = 9;
  localparam int OP_SHA512SIG0L  = 8;
  localparam int OP_SHA512SIG1H  = 7;
  localparam int OP_SHA512SIG1L  = 6;
  localparam int OP_SHA512SUM0R  = 5;
  localparam int OP_SHA512SUM1R  = 4;
  localparam int OP_SSM3P0       = 3;
  localparam int OP_SSM3P1       = 2;
  localparam int OP_SSM4_KS      = 1;
  localparam int OP_SSM4_ED      = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WB    = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/crypto_onehot_chk.sv
// Combinational legality check: the op field must have exactly one bit set.
module crypto_onehot_chk
  import crypto_seq_pkg::*;
(
  input  logic [OP_BITS_MSB:OP_BITS_LSB] op_bits,
  output logic                           legal
);

  logic [OP_BITS_MSB:OP_BITS_LSB] low_cleared;

  // Clearing the lowest set bit leaves zero only for a single-bit value.
  assign low_cleared = op_bits & (op_bits - 18'd1);
  assign legal       = (op_bits != '0) && (low_cleared == '0);

endmodule

// File: rtl/crypto_op_sequencer.sv
// Issues one legal scalar crypto op at a time to the shared datapath, stalls the core,
// enforces a WAIT timeout and presents a single writeback beat. Optional macro: CRYPTO_SEQ_PERF_EN.
module crypto_op_sequencer
  import crypto_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] crypto_instruction,
  input  logic [31:0]     rs1_val,
  input  logic [31:0]     rs2_val,
  input  logic [4:0]      rd,
  output logic            dp_start,
  output logic            dp_abort,
  output logic [OP_W-1:0] dp_op,
  output logic [31:0]     dp_a,
  output logic [31:0]     dp_b,
  input  logic            dp_done,
  input  logic [31:0]     dp_result,
  output logic            stall,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [31:0]     wb_data,
  output logic            err
`ifdef CRYPTO_SEQ_PERF_EN
  ,
  input  logic            perf_clr,
  output logic [31:0]     perf_ops,
  output logic [31:0]     perf_busy
`endif
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t          state_reg, state_next;
  logic [7:0]      cnt_reg, cnt_next;
  logic [OP_W-1:0] op_reg;
  logic [31:0]     a_reg, b_reg, res_reg;
  logic [4:0]      rd_reg;
  logic            err_reg, abort_reg;
  logic            legal, accept, timeout, in_flight, in_wb;

  crypto_onehot_chk u_chk (
    .op_bits (crypto_instruction[OP_BITS_MSB:OP_BITS_LSB]),
    .legal   (legal)
  );

  // req_ready is gated by rst so the core never sees a ready sequencer while held in reset.
  assign req_ready = (state_reg == ST_IDLE) && rst;
  assign accept    = req_valid && req_ready && !flush;
  assign in_flight = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
  assign in_wb     = (state_reg == ST_WB);

  assign stall    = accept || in_flight;
  assign dp_start = (state_reg == ST_ISSUE);
  assign dp_abort = abort_reg;
  assign dp_op    = in_flight ? op_reg : '0;
  assign dp_a     = in_flight ? a_reg  : '0;
  assign dp_b     = in_flight ? b_reg  : '0;
  assign wb_valid = in_wb && (rd_reg != 5'd0) && !flush;
  assign wb_rd    = in_wb ? rd_reg  : '0;
  assign wb_data  = in_wb ? res_reg : '0;
  assign err      = !flush && ((state_reg == ST_ERR) || err_reg);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    timeout    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = legal ? ST_ISSUE : ST_ERR;
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
        cnt_next   = 8'd0;
      end
      ST_WAIT: begin
        // done takes priority over an expiring timeout in the same cycle
        if (dp_done) begin
          state_next = ST_WB;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_IDLE;
          timeout    = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      ST_WB:   state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush) begin
      state_next = ST_IDLE;
      timeout    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      rd_reg    <= '0;
      res_reg   <= '0;
      err_reg   <= 1'b0;
      abort_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= timeout;
      abort_reg <= timeout || (flush && in_flight);
      if (accept) begin
        op_reg <= crypto_instruction;
        a_reg  <= rs1_val;
        b_reg  <= rs2_val;
        rd_reg <= rd;
      end
      if ((state_reg == ST_WAIT) && dp_done && !flush) res_reg <= dp_result;
    end
  end

`ifdef CRYPTO_SEQ_PERF_EN
  logic [31:0] perf_ops_reg, perf_busy_reg;
  logic        wb_beat;

  assign wb_beat   = in_wb && (wb_valid || (rd_reg == 5'd0));
  assign perf_ops  = perf_ops_reg;
  assign perf_busy = perf_busy_reg;

  always_ff @(posedge clk) begin
    if (!rst || perf_clr) begin
      perf_ops_reg  <= '0;
      perf_busy_reg <= '0;
    end else begin
      if (wb_beat && (perf_ops_reg != '1))  perf_ops_reg  <= perf_ops_reg + 32'd1;
      if (stall && (perf_busy_reg != '1))   perf_busy_reg <= perf_busy_reg + 32'd1;
    end
  end
`endif

endmodule
